expr_edit_buffer: RTL and testbench
===================================

Name: expr_edit_buffer

Overview:
- Consumer end of the keyboard token interface. Takes level-held key strobes and token codes from the keypad encoder and detects rising edges, so each press acts exactly once.
- Maintains the expression as an editable token array with a cursor. Supports insert-at-cursor, backspace, and cursor left/right.
- On eval, streams the stored tokens in order to the evaluator over a valid/ready handshake. Also exposes a random-read port for the display driver.

Parameters:
- width, 8, token code width (matches dataIn)
- depth, 32, maximum tokens stored
- aw, $clog2(depth+1), width of cursor/count/address fields

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- dataIn  in  width  token code from keypad encoder; valid whenever insert is high
- insert  in  1  level: key held
- del_pulse  in  1  level: delete key held
- ptrLeft_pulse  in  1  level: cursor-left held
- ptrRight_pulse  in  1  level: cursor-right held
- eval_pulse  in  1  level: eval key held
- tok_data  out  width  streamed token
- tok_valid  out  1  tok_data valid
- tok_last  out  1  final token of stream
- tok_ready  in  1  evaluator accepts token
- rd_addr  in  aw  display read address
- rd_data  out  width  mem[rd_addr]; 0 if rd_addr >= count (combinational)
- count  out  aw  tokens stored
- cursor  out  aw  insertion point, 0..count
- busy  out  1  streaming in progress
- full  out  1  count == depth
- err_full  out  1  one-cycle pulse: insert dropped because buffer full

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, cursor=0, state=IDLE.
  - All outputs 0.
  - Edge-detect history registers (prev_*) cleared to 0, so a key held through reset fires once after release.
  - Memory contents need not be cleared.
- Edge detection: per strobe, evt = level & ~prev; prev <= level every cycle in all states.
- Command latency: the command executes on the clock edge where evt=1. Results appear on count/cursor/rd_data the following cycle.
- Priority when several evt fire in one cycle: eval > insert > del > left > right. Only the highest-priority command executes; the others are discarded, not queued.
- FSM IDLE:
  - insert:
    - If count<depth: mem[k+1]<=mem[k] for all k in cursor..count-1 (single-cycle shift); mem[cursor]<=dataIn; count++; cursor++.
    - If full: no change; err_full=1 for one cycle.
  - del (backspace):
    - If cursor>0: mem[k-1]<=mem[k] for k in cursor..count-1; count--; cursor--.
    - If cursor==0: no-op.
  - left: cursor-- if cursor>0, else no-op.
  - right: cursor++ if cursor<count, else no-op.
  - eval:
    - If count>0: idx<=0; go to STREAM.
    - If count==0: no-op, stay IDLE.
- FSM STREAM:
  - busy=1, tok_valid=1, tok_data=mem[idx], tok_last=(idx==count-1).
  - On tok_valid & tok_ready: idx++. If tok_last, go to IDLE next cycle with tok_valid=0.
  - tok_data and tok_last stay stable while tok_valid=1 and tok_ready=0.
  - All edit and eval events in STREAM are discarded. prev_* still tracks, so a key held across the end of STREAM does not fire.
  - The buffer is retained after streaming; editing may resume.
- full = (count==depth), combinational from count.
- Asynchronous reset mid-STREAM: tok_valid drops immediately and the FSM returns to IDLE with an empty buffer.
- dataIn is sampled only on insert evt cycles; its value at other times is ignored.

Test Plan:
- Press '1'(0x01), '+'(0x2A), '2'(0x02), each held 5 cycles with 3-cycle gaps -> count=3, cursor=3, rd_data at addrs 0..2 = 01,2A,02; each key inserted once only.
- From [01,2A,02]: left, left, insert 0x1E -> [01,1E,2A,02], cursor=2. Then del -> [01,2A,02], cursor=1. Then left, left -> cursor=0. Then del -> no change.
- Fill 32 tokens, press insert again -> count stays 32, full=1, err_full high for exactly 1 cycle. Then right at cursor=32 -> no-op.
- With [01,2A,02], press eval; hold tok_ready=0 for 4 cycles, then toggle it 1/0 -> tokens 01,2A,02 in order, stable while stalled, tok_last only on 02, busy falls one cycle after the last handshake. An insert pressed during STREAM is not applied.
- Same cycle: insert and del rise together -> only the insert executes. Eval with count=0 -> stays IDLE, tok_valid never asserts.
- Hold insert high across a reset pulse mid-STREAM -> tok_valid drops asynchronously; after release, count=1 (one insert), busy=0.

Source files
------------

// File: rtl/expr_edit_buffer_if.sv
// Token stream handshake between the edit buffer (master) and the evaluator (slave).
interface expr_edit_buffer_if #(
    parameter int width = 8
);
    logic [width-1:0] tok_data;
    logic             tok_valid;
    logic             tok_last;
    logic             tok_ready;

    modport master (output tok_data, output tok_valid, output tok_last, input tok_ready);
    modport slave  (input tok_data, input tok_valid, input tok_last, output tok_ready);
endinterface

// File: rtl/expr_edit_buffer.sv
// Editable token buffer with a cursor: edge-detected key commands edit the array,
// eval streams the tokens out over valid/ready, and a side port serves the display.
module expr_edit_buffer #(
    parameter int width = 8,
    parameter int depth = 32,
    parameter int aw    = $clog2(depth + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [width-1:0]    dataIn,
    input  logic                insert,
    input  logic                del_pulse,
    input  logic                ptrLeft_pulse,
    input  logic                ptrRight_pulse,
    input  logic                eval_pulse,
    expr_edit_buffer_if.master  tok,
    input  logic [aw-1:0]       rd_addr,
    output logic [width-1:0]    rd_data,
    output logic [aw-1:0]       count,
    output logic [aw-1:0]       cursor,
    output logic                busy,
    output logic                full,
    output logic                err_full
);

    localparam int IW = (depth > 1) ? $clog2(depth) : 1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state_q, state_d;

    // key bits: [4] eval, [3] insert, [2] del, [1] left, [0] right (also priority order)
    logic [4:0] lvl, prev_q, evt;
    logic [width-1:0] mem [depth];
    logic [aw-1:0] idx_q;
    logic do_ins, do_del, do_left, do_right, do_eval;
    logic hs, last;
    logic ins_ok, del_ok;

    assign lvl = {eval_pulse, insert, del_pulse, ptrLeft_pulse, ptrRight_pulse};
    assign evt = lvl & ~prev_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) prev_q <= '0;
        else        prev_q <= lvl;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        do_ins   = 1'b0;
        do_del   = 1'b0;
        do_left  = 1'b0;
        do_right = 1'b0;
        do_eval  = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt[4]) begin
                    if (count != '0) begin
                        do_eval = 1'b1;
                        state_d = STREAM;
                    end
                end
                else if (evt[3]) do_ins   = 1'b1;
                else if (evt[2]) do_del   = 1'b1;
                else if (evt[1]) do_left  = 1'b1;
                else if (evt[0]) do_right = 1'b1;
            end
            STREAM: begin
                if (hs && last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q == STREAM);
    assign tok.tok_valid = busy;
    assign last          = (idx_q == count - aw'(1));
    assign tok.tok_last  = busy & last;
    assign tok.tok_data  = busy ? mem[idx_q[IW-1:0]] : '0;
    assign hs            = busy & tok.tok_ready;

    assign full    = (count == aw'(depth));
    assign rd_data = (rd_addr < count) ? mem[rd_addr[IW-1:0]] : '0;

    assign ins_ok = do_ins & ~full;
    assign del_ok = do_del & (cursor != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            cursor   <= '0;
            idx_q    <= '0;
            err_full <= 1'b0;
        end
        else begin
            err_full <= do_ins & full;
            if (ins_ok) begin
                count  <= count + aw'(1);
                cursor <= cursor + aw'(1);
            end
            if (del_ok) begin
                count  <= count - aw'(1);
                cursor <= cursor - aw'(1);
            end
            if (do_left && cursor != '0)     cursor <= cursor - aw'(1);
            if (do_right && cursor < count)  cursor <= cursor + aw'(1);
            if (do_eval)                     idx_q  <= '0;
            else if (hs)                     idx_q  <= idx_q + aw'(1);
        end
    end

    // Whole-array shift in one cycle: insert opens a gap at cursor, delete closes the one before it.
    always_ff @(posedge clock) begin
        for (int k = 0; k < depth; k++) begin
            if (ins_ok) begin
                if (k == int'(cursor))
                    mem[k] <= dataIn;
                else if (k > int'(cursor) && k <= int'(count))
                    mem[k] <= mem[(k > 0) ? k - 1 : 0];
            end
            else if (del_ok) begin
                if (k >= int'(cursor) - 1 && k < int'(count) - 1)
                    mem[k] <= mem[(k < depth - 1) ? k + 1 : k];
            end
        end
    end

endmodule

// File: tb/tb_expr_edit_buffer.sv
// Self-checking bench: queue model of the token array plus a scoreboard for the token stream.
module tb_expr_edit_buffer;

    localparam int W  = 8;
    localparam int D  = 32;
    localparam int AW = $clog2(D + 1);

    localparam logic [4:0] K_EVAL = 5'b10000;
    localparam logic [4:0] K_INS  = 5'b01000;
    localparam logic [4:0] K_DEL  = 5'b00100;
    localparam logic [4:0] K_LEFT = 5'b00010;
    localparam logic [4:0] K_RGT  = 5'b00001;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [W-1:0]  dataIn = '0;
    logic          insert = 1'b0, del_pulse = 1'b0, ptrLeft_pulse = 1'b0;
    logic          ptrRight_pulse = 1'b0, eval_pulse = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic [AW-1:0] count, cursor;
    logic          busy, full, err_full;

    expr_edit_buffer_if #(.width(W)) tok_if ();

    expr_edit_buffer #(.width(W), .depth(D)) dut (
        .clock(clock), .reset(reset), .dataIn(dataIn), .insert(insert),
        .del_pulse(del_pulse), .ptrLeft_pulse(ptrLeft_pulse),
        .ptrRight_pulse(ptrRight_pulse), .eval_pulse(eval_pulse), .tok(tok_if),
        .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .cursor(cursor),
        .busy(busy), .full(full), .err_full(err_full)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] mq[$];
    int mcur = 0;
    logic [W:0] sb[$];
    int err_seen = 0;
    logic vld_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake happens on the next rising edge; compare it against the scoreboard head.
    always @(negedge clock) begin
        #2;
        if (tok_if.tok_valid && tok_if.tok_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else begin
                logic [W:0] e;
                e = sb.pop_front();
                chk("tok_data", 32'(tok_if.tok_data), 32'(e[W-1:0]));
                chk("tok_last", 32'(tok_if.tok_last), 32'(e[W]));
            end
        end
    end

    task automatic model(input logic [4:0] keys, input logic [W-1:0] d);
        if (keys[4]) begin
            for (int i = 0; i < mq.size(); i++) sb.push_back({(i == mq.size() - 1), mq[i]});
        end
        else if (keys[3]) begin
            if (mq.size() < D) begin mq.insert(mcur, d); mcur++; end
        end
        else if (keys[2]) begin
            if (mcur > 0) begin mq.delete(mcur - 1); mcur--; end
        end
        else if (keys[1]) begin
            if (mcur > 0) mcur--;
        end
        else if (keys[0]) begin
            if (mcur < mq.size()) mcur++;
        end
    endtask

    task automatic press(input logic [4:0] keys, input logic [W-1:0] d, input int hold, input int gap);
        {eval_pulse, insert, del_pulse, ptrLeft_pulse, ptrRight_pulse} = keys;
        dataIn = d;
        model(keys, d);
        for (int i = 0; i < hold + gap; i++) begin
            if (i == hold) begin
                {eval_pulse, insert, del_pulse, ptrLeft_pulse, ptrRight_pulse} = '0;
                dataIn = 8'hEE;
            end
            @(negedge clock);
            err_seen += int'(err_full);
            vld_seen |= tok_if.tok_valid;
        end
    endtask

    task automatic check_buf(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".cursor"}, 32'(cursor), 32'(mcur));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == D));
        for (int i = 0; i < mq.size(); i++) begin
            rd_addr = AW'(i);
            #1;
            chk({tag, ".rd"}, 32'(rd_data), 32'(mq[i]));
        end
        rd_addr = AW'(mq.size());
        #1;
        chk({tag, ".rd_oob"}, 32'(rd_data), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        tok_if.tok_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.cursor", 32'(cursor), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(tok_if.tok_valid), 32'd0);
        chk("rst.err", 32'(err_full), 32'd0);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.rd", 32'(rd_data), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        vld_seen = 1'b0;
        press(K_EVAL, 8'h00, 2, 3);
        chk("eval_empty.valid", 32'(vld_seen), 32'd0);
        chk("eval_empty.busy", 32'(busy), 32'd0);

        press(K_INS, 8'h01, 5, 3);
        press(K_INS, 8'h2A, 5, 3);
        press(K_INS, 8'h02, 5, 3);
        check_buf("type3");

        press(K_LEFT, 8'h00, 2, 2);
        press(K_LEFT, 8'h00, 2, 2);
        press(K_INS, 8'h1E, 2, 2);
        check_buf("mid_ins");
        press(K_DEL, 8'h00, 2, 2);
        check_buf("mid_del");
        press(K_LEFT, 8'h00, 2, 2);
        press(K_LEFT, 8'h00, 2, 2);
        check_buf("home");
        press(K_DEL, 8'h00, 2, 2);
        check_buf("del_home");

        // stream with a stall and an insert that must be ignored
        tok_if.tok_ready = 1'b0;
        press(K_EVAL, 8'h00, 2, 1);
        insert = 1'b1;
        dataIn = 8'h77;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) insert = 1'b0;
            @(negedge clock);
            #2;
            chk("stall.valid", 32'(tok_if.tok_valid), 32'd1);
            chk("stall.data", 32'(tok_if.tok_data), 32'h01);
            chk("stall.last", 32'(tok_if.tok_last), 32'd0);
        end
        begin
            bit done;
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                @(negedge clock);
                tok_if.tok_ready = ~tok_if.tok_ready;
                #2;
                if (tok_if.tok_valid && tok_if.tok_ready && tok_if.tok_last) begin
                    done = 1'b1;
                    @(negedge clock);
                    tok_if.tok_ready = 1'b0;
                    #3;
                    chk("stream_end.busy", 32'(busy), 32'd0);
                    chk("stream_end.valid", 32'(tok_if.tok_valid), 32'd0);
                end
            end
            if (!done) chk("stream_timeout", 32'd0, 32'd1);
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        @(negedge clock);
        check_buf("after_stream");

        press(K_INS | K_DEL, 8'h33, 2, 2);
        check_buf("ins_del");

        for (int i = 0; i < 40 && mq.size() < D; i++) press(K_INS, W'(8'h40 + i), 1, 1);
        for (int i = 0; i < 40 && mcur < mq.size(); i++) press(K_RGT, 8'h00, 1, 1);
        check_buf("filled");
        err_seen = 0;
        press(K_INS, 8'h99, 3, 3);
        chk("overflow.err_pulses", 32'(err_seen), 32'd1);
        check_buf("overflow");
        press(K_RGT, 8'h00, 2, 2);
        check_buf("right_end");

        // reset while streaming with insert held through it
        press(K_EVAL, 8'h00, 2, 1);
        chk("pre_rst.busy", 32'(busy), 32'd1);
        insert = 1'b1;
        dataIn = 8'h55;
        repeat (2) @(negedge clock);
        #3 reset = 1'b0;
        #1;
        chk("async_rst.valid", 32'(tok_if.tok_valid), 32'd0);
        chk("async_rst.count", 32'(count), 32'd0);
        sb.delete();
        mq.delete();
        mcur = 0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        insert = 1'b0;
        mq.push_back(8'h55);
        mcur = 1;
        repeat (2) @(negedge clock);
        chk("post_rst.busy", 32'(busy), 32'd0);
        check_buf("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
